// File: rtl/prio_scan_pkg.sv
// Shared types and sizing helpers for the chunked priority scan encoder.
package prio_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned nchunk(input int unsigned n, input int unsigned chunk);
    return (n + chunk - 1) / chunk;
  endfunction

  // Index/pointer width that stays at least one bit for degenerate sizes.
  function automatic int unsigned ptr_width(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/chunk_prio_encode.sv
// Combinational priority encoder for one CHUNK-bit slice, MSB-first or LSB-first.
module chunk_prio_encode
  import prio_scan_pkg::*;
#(
  parameter int unsigned CHUNK = 32,
  parameter int unsigned CW    = ptr_width(CHUNK)
) (
  input  logic [CHUNK-1:0] i_slice,
  input  logic             i_lsb,
  output logic             o_nz_c,
  output logic [CW-1:0]    o_idx_c
);

  // The last matching assignment wins, so loop direction picks highest or lowest.
  always_comb begin
    o_nz_c  = |i_slice;
    o_idx_c = '0;
    if (i_lsb) begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (i_slice[i]) o_idx_c = CW'(i);
      end
    end else begin
      for (int i = 0; i < CHUNK; i++) begin
        if (i_slice[i]) o_idx_c = CW'(i);
      end
    end
  end

endmodule

// File: rtl/prio_scan_encode.sv
// Multi-cycle MSB/LSB priority encoder scanning one chunk per clock.
// Optional PRIO_SCAN_EARLY_EXIT_EN: leave SCAN on the first nonzero chunk.
module prio_scan_encode
  import prio_scan_pkg::*;
#(
  parameter int unsigned N     = 255,
  parameter int unsigned CHUNK = 32,
  parameter int unsigned IW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_lsb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_index,
  output logic          out_zero
);

  localparam int unsigned NCHUNK = nchunk(N, CHUNK);
  localparam int unsigned PW     = ptr_width(NCHUNK);
  localparam int unsigned CW     = ptr_width(CHUNK);
  localparam int unsigned DW     = NCHUNK * CHUNK;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [DW-1:0]  r_data;
  logic           r_lsb;
  logic [PW-1:0]  r_ptr;
  logic           r_found;
  logic [IW-1:0]  r_index;
  logic           r_out_valid;
  logic [IW-1:0]  r_out_index;
  logic           r_out_zero;

  logic [CHUNK-1:0] w_slice;
  logic             w_nz;
  logic [CW-1:0]    w_loc;
  logic             w_accept;
  logic             w_last;
  logic             w_hit;
  logic             w_exit;
  logic             w_found_nxt;
  logic [IW:0]      w_idx_wide;
  logic [IW-1:0]    w_index_nxt;

  assign w_slice = r_data[int'(r_ptr) * CHUNK +: CHUNK];

  chunk_prio_encode #(
    .CHUNK (CHUNK),
    .CW    (CW)
  ) u_chunk (
    .i_slice (w_slice),
    .i_lsb   (r_lsb),
    .o_nz_c  (w_nz),
    .o_idx_c (w_loc)
  );

  // Scan bookkeeping: end-of-operand detection and first-hit index.
  always_comb begin
    w_last      = r_lsb ? (r_ptr == PW'(NCHUNK - 1)) : (r_ptr == '0);
    w_hit       = !r_found && w_nz;
    w_found_nxt = r_found || w_nz;
    w_idx_wide  = (IW+1)'(r_ptr) * (IW+1)'(CHUNK) + (IW+1)'(w_loc);
    w_index_nxt = w_hit ? IW'(w_idx_wide) : r_index;
`ifdef PRIO_SCAN_EARLY_EXIT_EN
    w_exit      = w_last || w_hit;
`else
    w_exit      = w_last;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = SCAN;
      SCAN:    if (w_exit)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    w_accept  = in_valid && in_ready;
    out_valid = r_out_valid;
    out_index = r_out_index;
    out_zero  = r_out_zero;
  end

  // Operand capture, per-chunk scan and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= '0;
      r_lsb       <= 1'b0;
      r_ptr       <= '0;
      r_found     <= 1'b0;
      r_index     <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_out_zero  <= 1'b0;
    end else if (w_accept) begin
      r_data  <= DW'(in_data);
      r_lsb   <= in_lsb;
      r_ptr   <= in_lsb ? '0 : PW'(NCHUNK - 1);
      r_found <= 1'b0;
      r_index <= '0;
    end else if (r_state == SCAN) begin
      r_found <= w_found_nxt;
      r_index <= w_index_nxt;
      if (!w_last) r_ptr <= r_lsb ? r_ptr + PW'(1) : r_ptr - PW'(1);
      if (w_exit) begin
        r_out_valid <= 1'b1;
        r_out_zero  <= !w_found_nxt;
        r_out_index <= w_found_nxt ? w_index_nxt : '0;
      end
    end else if (r_state == DONE && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_scan_encode.sv
// Directed and seeded-random checks of prio_scan_encode (N=255, CHUNK=32).
module tb_prio_scan_encode;

  localparam int unsigned N  = 255;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_lsb;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          out_zero;

  int checks   = 0;
  int failures = 0;

  prio_scan_encode #(.N(N), .CHUNK(32), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_lsb    (in_lsb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected latency: fixed 8, or visited-chunk count with early exit.
  function automatic int exp_lat(input int early);
`ifdef PRIO_SCAN_EARLY_EXIT_EN
    return early;
`else
    return (early > 0) ? 8 : 8;
`endif
  endfunction

  task automatic send(input logic [N-1:0] d, input logic lsb);
    @(negedge clk);
    in_data  = d;
    in_lsb   = lsb;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = N'({$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()});
    in_lsb   = ~lsb;
  endtask

  task automatic wait_res(input string tag, input int lat_exp, input int idx_exp, input logic zero_exp);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"},  32'(lat), 32'(lat_exp));
    chk({tag, "_idx"},  32'(out_index), 32'(idx_exp));
    chk({tag, "_zero"}, 32'(out_zero), 32'(zero_exp));
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  logic [N-1:0] one;
  logic [N-1:0] rd;
  int           r_idx;
  logic         r_zero;
  int           r_early;
  logic         r_lsb;

  initial begin
    one       = N'(1);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_lsb    = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_zero",  32'(out_zero),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset three cycles into a scan, then a clean operation.
    send(one << 7, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midscan_rst_ready", 32'(in_ready),  32'd1);
    chk("midscan_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(one << 5, 1'b0);
    wait_res("bit5_msb", exp_lat(8), 5, 1'b0);
    take("bit5_msb");

    send('0, 1'b0);
    wait_res("zero_msb", 8, 0, 1'b1);
    take("zero_msb");
    send('0, 1'b1);
    wait_res("zero_lsb", 8, 0, 1'b1);
    take("zero_lsb");

    send('1, 1'b0);
    wait_res("ones_msb", exp_lat(1), 254, 1'b0);
    take("ones_msb");
    send('1, 1'b1);
    wait_res("ones_lsb", exp_lat(1), 0, 1'b0);
    take("ones_lsb");

    send(N'(32'hFFFF_FFFF), 1'b0);
    wait_res("low32_msb", 8, 31, 1'b0);
    take("low32_msb");
    send(one << 200, 1'b0);
    wait_res("bit200_msb", exp_lat(2), 200, 1'b0);
    take("bit200_msb");
    send(one << 200, 1'b1);
    wait_res("bit200_lsb", exp_lat(7), 200, 1'b0);
    take("bit200_lsb");
    send(one << 254, 1'b1);
    wait_res("bit254_lsb", 8, 254, 1'b0);
    take("bit254_lsb");

    // Back-pressure with a second operand waiting.
    send(one << 100, 1'b0);
    wait_res("bp_first", exp_lat(5), 100, 1'b0);
    @(negedge clk);
    in_data  = one << 9;
    in_lsb   = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_index", 32'(out_index), 32'd100);
      chk("bp_hold_zero",  32'(out_zero),  32'd0);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_hs_valid",       32'(out_valid), 32'd0);
    chk("bp_hs_no_accept",   32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    chk("bp_next_accepted",  32'(in_ready),  32'd0);
    in_valid = 1'b0;
    wait_res("bp_second", exp_lat(1), 9, 1'b0);
    take("bp_second");

    // Seeded random sparse operands against a bit-loop reference.
    for (int t = 0; t < 24; t++) begin
      rd = '0;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        rd[$urandom_range(0, N - 1)] = 1'b1;
      r_lsb  = 1'($urandom_range(0, 1));
      r_zero = 1'b1;
      r_idx  = 0;
      if (r_lsb) begin
        for (int b = N - 1; b >= 0; b--) if (rd[b]) begin r_idx = b; r_zero = 1'b0; end
      end else begin
        for (int b = 0; b < N; b++) if (rd[b]) begin r_idx = b; r_zero = 1'b0; end
      end
      if (r_zero)     r_early = 8;
      else if (r_lsb) r_early = r_idx / 32 + 1;
      else            r_early = 8 - r_idx / 32;
      send(rd, r_lsb);
      wait_res("rand", exp_lat(r_early), r_idx, r_zero);
      take("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
